song_playback_ctrl: RTL

//  Playback controller directly upstream of song_progression. Turns debounced

---
 rtl/song_playback_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/song_playback_ctrl.sv
// Playback controller: play/pause/restart sequencing, millisecond elapsed-time
// counter and proportional progress-bar fill for the bar renderer.
module song_playback_ctrl #(
    parameter int unsigned CLKS_PER_MS = 100_000,
    parameter int unsigned BAR_STEPS   = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play_btn,
    input  logic        restart_btn,
    input  logic        song_end_in,
    input  logic [17:0] song_len_ms,
    output logic        play,
    output logic        song_done,
    output logic        reset_player,
    output logic [17:0] elapsed_ms,
    output logic [7:0]  progress_px
);

    localparam int unsigned LEN_W = 18;
    localparam int unsigned PX_W  = 8;
    localparam int unsigned ACC_W = LEN_W + 1;
    localparam int unsigned PRE_W = $clog2(CLKS_PER_MS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAYING,
        ST_PAUSED,
        ST_DONE
    } state_t;

    state_t             state, state_n;
    logic [PRE_W-1:0]   pre, pre_n;
    logic [LEN_W-1:0]   elapsed, elapsed_n;
    logic [LEN_W-1:0]   len, len_n;
    logic [ACC_W-1:0]   acc, acc_n;
    logic [PX_W-1:0]    progress, progress_n;
    logic               play_n, done_n, rp_n;

    logic               tick;
    logic [ACC_W-1:0]   acc_sum;
    logic [LEN_W-1:0]   elapsed_inc;

    assign tick        = (state == ST_PLAYING) && (pre == PRE_W'(CLKS_PER_MS - 1));
    assign acc_sum     = acc + ACC_W'(BAR_STEPS);
    assign elapsed_inc = elapsed + LEN_W'(1);

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            pre          <= '0;
            elapsed      <= '0;
            len          <= '0;
            acc          <= '0;
            progress     <= '0;
            play         <= 1'b0;
            song_done    <= 1'b0;
            reset_player <= 1'b0;
        end else begin
            state        <= state_n;
            pre          <= pre_n;
            elapsed      <= elapsed_n;
            len          <= len_n;
            acc          <= acc_n;
            progress     <= progress_n;
            play         <= play_n;
            song_done    <= done_n;
            reset_player <= rp_n;
        end
    end

    assign elapsed_ms  = elapsed;
    assign progress_px = progress;

    // Next-state, counters and output decode
    always_comb begin
        state_n    = state;
        pre_n      = pre;
        elapsed_n  = elapsed;
        len_n      = len;
        acc_n      = acc;
        progress_n = progress;
        rp_n       = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (play_btn) begin
                    state_n    = ST_PLAYING;
                    len_n      = (song_len_ms < LEN_W'(BAR_STEPS)) ? LEN_W'(BAR_STEPS) : song_len_ms;
                    pre_n      = '0;
                    elapsed_n  = '0;
                    acc_n      = '0;
                    progress_n = '0;
                    rp_n       = 1'b1;
                end
            end
            ST_PLAYING: begin
                if (tick) begin
                    pre_n     = '0;
                    elapsed_n = elapsed_inc;
                    if (acc_sum >= ACC_W'(len)) begin
                        acc_n = acc_sum - ACC_W'(len);
                        if (progress < PX_W'(BAR_STEPS)) begin
                            progress_n = progress + PX_W'(1);
                        end
                    end else begin
                        acc_n = acc_sum;
                    end
                end else begin
                    pre_n = pre + PRE_W'(1);
                end
                // Completion outranks a pause request arriving on the same tick
                if ((tick && (elapsed_inc == len)) || song_end_in) begin
                    state_n    = ST_DONE;
                    progress_n = PX_W'(BAR_STEPS);
                end else if (play_btn) begin
                    state_n = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (play_btn) begin
                    state_n = ST_PLAYING;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (restart_btn) begin
            state_n    = ST_IDLE;
            pre_n      = '0;
            elapsed_n  = '0;
            acc_n      = '0;
            progress_n = '0;
            rp_n       = 1'b1;
        end

        play_n = (state_n == ST_PLAYING);
        done_n = (state_n == ST_DONE);
    end

endmodule
